// File: rtl/ysyx_23060025_bpu_pkg.sv
// ysyx_23060025_bpu_pkg: shared FSM state encodings, counter constants and counter math for the BPU
package ysyx_23060025_bpu_pkg;

   typedef enum logic [1:0] {
      BPU_INIT = 2'd0,
      BPU_RUN  = 2'd1,
      BPU_HALT = 2'd2
   } bpu_state_e;

   localparam logic [1:0] CTR_WEAK_T   = 2'b10;
   localparam logic [1:0] CTR_STRONG_T = 2'b11;

   // 2-bit saturating step towards taken (t=1) or not-taken (t=0)
   function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic t);
      return t ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
   endfunction

endpackage

// File: rtl/ysyx_23060025_btb.sv
// ysyx_23060025_btb: direct-mapped BTB storage with a lookup read port, an update read port, one write port and a sweep-clear port
module ysyx_23060025_btb
   import ysyx_23060025_bpu_pkg::*;
#(
   parameter  int ADDR_WIDTH  = 32,
   parameter  int BTB_ENTRIES = 8,
   localparam int IDX_W       = $clog2(BTB_ENTRIES),
   localparam int TAG_W       = ADDR_WIDTH - IDX_W - 2,
   localparam int TGT_W       = ADDR_WIDTH - 2
) (
   input  logic             clock,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic             o_rd_vld,
   output logic [TAG_W-1:0] o_rd_tag,
   output logic [TGT_W-1:0] o_rd_tgt,
   output logic [1:0]       o_rd_ctr,
   input  logic [IDX_W-1:0] i_up_idx,
   output logic             o_up_vld,
   output logic [TAG_W-1:0] o_up_tag,
   output logic [1:0]       o_up_ctr,
   input  logic             i_wr,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [TAG_W-1:0] i_wr_tag,
   input  logic             i_wr_tgt_en,
   input  logic [TGT_W-1:0] i_wr_tgt,
   input  logic [1:0]       i_wr_ctr,
   input  logic             i_clr,
   input  logic [IDX_W-1:0] i_clr_idx
);

   logic             r_vld [BTB_ENTRIES];
   logic [TAG_W-1:0] r_tag [BTB_ENTRIES];
   logic [TGT_W-1:0] r_tgt [BTB_ENTRIES];
   logic [1:0]       r_ctr [BTB_ENTRIES];

   assign o_rd_vld = r_vld[i_rd_idx];
   assign o_rd_tag = r_tag[i_rd_idx];
   assign o_rd_tgt = r_tgt[i_rd_idx];
   assign o_rd_ctr = r_ctr[i_rd_idx];
   assign o_up_vld = r_vld[i_up_idx];
   assign o_up_tag = r_tag[i_up_idx];
   assign o_up_ctr = r_ctr[i_up_idx];

   // Storage is deliberately unreset: valid bits are cleared one per cycle by the sweep
   always_ff @(posedge clock) begin
      if (i_clr) begin
         r_vld[i_clr_idx] <= 1'b0;
      end else if (i_wr) begin
         r_vld[i_wr_idx] <= 1'b1;
         r_tag[i_wr_idx] <= i_wr_tag;
         r_ctr[i_wr_idx] <= i_wr_ctr;
         if (i_wr_tgt_en) r_tgt[i_wr_idx] <= i_wr_tgt;
      end
   end

endmodule

// File: rtl/ysyx_23060025_bpu.sv
// ysyx_23060025_bpu: next-PC predictor with sweep-clear FSM, BTB training from idu and halt on ebreak
module ysyx_23060025_bpu
   import ysyx_23060025_bpu_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int BTB_ENTRIES = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] fs_pc_i,
   output logic [ADDR_WIDTH-1:0] bpu_pc_predict_o,
   output logic                  bpu_valid_o,
   input  logic                  upd_valid_i,
   input  logic                  upd_is_jump_i,
   input  logic [ADDR_WIDTH-1:0] upd_pc_i,
   input  logic                  upd_taken_i,
   input  logic [ADDR_WIDTH-1:0] upd_target_i,
   input  logic                  flush_i,
   input  logic                  ebreak_i
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
   localparam int TGT_W = ADDR_WIDTH - 2;

   bpu_state_e       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_sweep_idx;
   logic             w_rd_vld, w_up_vld, w_rd_hit, w_up_hit, w_taken, w_wr;
   logic [TAG_W-1:0] w_rd_tag, w_up_tag;
   logic [TGT_W-1:0] w_rd_tgt;
   logic [1:0]       w_rd_ctr, w_up_ctr, w_wr_ctr;

   ysyx_23060025_btb #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BTB_ENTRIES(BTB_ENTRIES)
   ) u_btb (
      .clock      (clock),
      .i_rd_idx   (fs_pc_i[IDX_W+1:2]),
      .o_rd_vld   (w_rd_vld),
      .o_rd_tag   (w_rd_tag),
      .o_rd_tgt   (w_rd_tgt),
      .o_rd_ctr   (w_rd_ctr),
      .i_up_idx   (upd_pc_i[IDX_W+1:2]),
      .o_up_vld   (w_up_vld),
      .o_up_tag   (w_up_tag),
      .o_up_ctr   (w_up_ctr),
      .i_wr       (w_wr),
      .i_wr_idx   (upd_pc_i[IDX_W+1:2]),
      .i_wr_tag   (upd_pc_i[ADDR_WIDTH-1:IDX_W+2]),
      .i_wr_tgt_en(w_taken),
      .i_wr_tgt   (upd_target_i[ADDR_WIDTH-1:2]),
      .i_wr_ctr   (w_wr_ctr),
      .i_clr      (r_state == BPU_INIT),
      .i_clr_idx  (r_sweep_idx)
   );

   // Lookup is masked while sweeping so not-yet-cleared entries never leak a target
   assign w_rd_hit = (r_state != BPU_INIT) & w_rd_vld & (w_rd_tag == fs_pc_i[ADDR_WIDTH-1:IDX_W+2]);
   assign bpu_pc_predict_o = (w_rd_hit & w_rd_ctr[1]) ? {w_rd_tgt, 2'b00} : fs_pc_i + ADDR_WIDTH'(4);
   assign bpu_valid_o = (r_state == BPU_RUN);

   // Jumps are always treated as taken regardless of the taken flag
   assign w_taken  = upd_taken_i | upd_is_jump_i;
   assign w_up_hit = w_up_vld & (w_up_tag == upd_pc_i[ADDR_WIDTH-1:IDX_W+2]);
   assign w_wr     = (r_state == BPU_RUN) & ~ebreak_i & ~flush_i & upd_valid_i & (w_up_hit | w_taken);
   assign w_wr_ctr = upd_is_jump_i ? CTR_STRONG_T : w_up_hit ? ctr_next(w_up_ctr, upd_taken_i) : CTR_WEAK_T;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= BPU_INIT;
      else        r_state <= w_state_nxt;
   end

   // Sweep pointer advances only in INIT and rests at zero otherwise, so a flush restarts from entry 0
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                    r_sweep_idx <= '0;
      else if (r_state == BPU_INIT)  r_sweep_idx <= r_sweep_idx + 1'b1;
      else                           r_sweep_idx <= '0;
   end

   // Next-state: sweep completes on the last entry; ebreak wins over flush in RUN; HALT is terminal
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         BPU_INIT: if (r_sweep_idx == IDX_W'(BTB_ENTRIES - 1)) w_state_nxt = BPU_RUN;
         BPU_RUN:  if (ebreak_i) w_state_nxt = BPU_HALT;
                   else if (flush_i) w_state_nxt = BPU_INIT;
         default:  w_state_nxt = r_state;
      endcase
   end

endmodule
